// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg -- shared encodings for the countdown timer controller. Rev 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_SEC  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/countdown_timer_ctrl_if.sv
// ============================================================================
// countdown_timer_ctrl_if -- tick/key inputs and display/alarm outputs. Rev 1.0
// ============================================================================
`default_nettype none

interface countdown_timer_ctrl_if;
  import timer_pkg::*;

  logic             sec_pulse;
  logic             key_start;
  logic             key_set;
  logic             key_inc;
  logic             key_clr;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [1:0]       set_field;
  logic             running;
  logic             alarm;

  modport master (
    output sec_pulse, key_start, key_set, key_inc, key_clr,
    input  min_tens, min_ones, sec_tens, sec_ones, set_field, running, alarm
  );

  modport slave (
    input  sec_pulse, key_start, key_set, key_inc, key_clr,
    output min_tens, min_ones, sec_tens, sec_ones, set_field, running, alarm
  );

endinterface

`default_nettype wire

// File: rtl/bcd_2digit_counter.sv
// ============================================================================
// bcd_2digit_counter -- two-digit BCD up/down counter wrapping at LIMIT. Rev 1.0
// ============================================================================
`default_nettype none

module bcd_2digit_counter
  import timer_pkg::*;
#(
  parameter int LIMIT = 59
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clr,
  input  wire logic               load,
  input  wire logic [2*BCD_W-1:0] load_val,
  input  wire logic               inc,
  input  wire logic               dec,
  output logic      [BCD_W-1:0]   tens,
  output logic      [BCD_W-1:0]   ones,
  output logic                    is_zero,
  output logic                    borrow
);

  localparam logic [BCD_W-1:0] LIM_TENS = BCD_W'(LIMIT / 10);
  localparam logic [BCD_W-1:0] LIM_ONES = BCD_W'(LIMIT % 10);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             at_limit;

  assign at_limit = (tens_q == LIM_TENS) && (ones_q == LIM_ONES);
  assign is_zero  = (tens_q == '0) && (ones_q == '0);
  assign borrow   = dec && is_zero;
  assign tens     = tens_q;
  assign ones     = ones_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (load) begin
      {tens_d, ones_d} = load_val;
    end else if (inc) begin
      if (at_limit) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec) begin
      if (is_zero) begin
        tens_d = LIM_TENS;
        ones_d = LIM_ONES;
      end else if (ones_q == '0) begin
        tens_d = tens_q - 4'd1;
        ones_d = 4'd9;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
// ============================================================================
// countdown_timer_ctrl -- MM:SS countdown with preset, pause and alarm. Rev 1.0
// ============================================================================
`default_nettype none

module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int MAX_MIN    = 59,
  parameter int ALARM_SECS = 5
) (
  input wire logic              clk,
  input wire logic              rst_n,
  countdown_timer_ctrl_if.slave bus
);

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS);

  state_e             state_q, state_d;
  logic [3:0]         alarm_cnt_q, alarm_cnt_d;
  logic [4*BCD_W-1:0] pre_q, pre_d;
  logic [1:0]         set_field_q, set_field_d;
  logic               running_q, running_d;
  logic               alarm_q, alarm_d;

  logic ctr_clr, ctr_load, sec_inc, sec_dec, min_inc;
  logic clr_all;
  logic min_is_zero, sec_is_zero, sec_borrow, min_borrow;
  logic cur_is_zero, cur_is_one;
  logic [BCD_W-1:0] min_tens, min_ones, sec_tens, sec_ones;

  assign cur_is_zero = min_is_zero && sec_is_zero;
  assign cur_is_one  = min_is_zero && (sec_tens == '0) && (sec_ones == 4'd1);
  // A whole-time underflow cannot occur in normal sequencing; saturate at 00:00.
  assign clr_all     = ctr_clr || min_borrow;

  bcd_2digit_counter #(.LIMIT(59)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .load(ctr_load),
    .load_val(pre_q[2*BCD_W-1:0]), .inc(sec_inc), .dec(sec_dec),
    .tens(sec_tens), .ones(sec_ones), .is_zero(sec_is_zero), .borrow(sec_borrow)
  );

  bcd_2digit_counter #(.LIMIT(MAX_MIN)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clr_all), .load(ctr_load),
    .load_val(pre_q[4*BCD_W-1:2*BCD_W]), .inc(min_inc), .dec(sec_borrow),
    .tens(min_tens), .ones(min_ones), .is_zero(min_is_zero), .borrow(min_borrow)
  );

  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    pre_d       = pre_q;
    ctr_clr     = 1'b0;
    ctr_load    = 1'b0;
    sec_inc     = 1'b0;
    sec_dec     = 1'b0;
    min_inc     = 1'b0;
    if (bus.key_clr) begin
      state_d     = ST_IDLE;
      ctr_clr     = 1'b1;
      pre_d       = '0;
      alarm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.key_start && !cur_is_zero) state_d = ST_RUN;
          else if (bus.key_set)              state_d = ST_SET_MIN;
        end
        ST_SET_MIN: begin
          if (bus.key_set)      state_d = ST_SET_SEC;
          else if (bus.key_inc) min_inc = 1'b1;
        end
        ST_SET_SEC: begin
          if (bus.key_set) begin
            state_d = ST_IDLE;
            pre_d   = {min_tens, min_ones, sec_tens, sec_ones};
          end else if (bus.key_inc) begin
            sec_inc = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.sec_pulse) begin
            sec_dec = 1'b1;
            // Reaching 00:00 outranks a simultaneous pause request.
            if (cur_is_one) begin
              state_d     = ST_DONE;
              alarm_cnt_d = '0;
            end else if (bus.key_start) begin
              state_d = ST_PAUSE;
            end
          end else if (bus.key_start) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.key_start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (bus.sec_pulse) begin
            alarm_cnt_d = alarm_cnt_q + 4'd1;
            if (alarm_cnt_d == ALARM_LAST) begin
              state_d  = ST_IDLE;
              ctr_load = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    set_field_d = (state_d == ST_SET_MIN) ? FIELD_MIN :
                  (state_d == ST_SET_SEC) ? FIELD_SEC : FIELD_NONE;
    running_d   = (state_d == ST_RUN);
    alarm_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alarm_cnt_q <= '0;
      pre_q       <= '0;
      set_field_q <= FIELD_NONE;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      pre_q       <= pre_d;
      set_field_q <= set_field_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.min_tens  = min_tens;
  assign bus.min_ones  = min_ones;
  assign bus.sec_tens  = sec_tens;
  assign bus.sec_ones  = sec_ones;
  assign bus.set_field = set_field_q;
  assign bus.running   = running_q;
  assign bus.alarm     = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
// ============================================================================
// tb_countdown_timer_ctrl -- directed scenarios plus random keys vs. a model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_countdown_timer_ctrl;

  localparam int MAX_MIN    = 59;
  localparam int ALARM_SECS = 5;
  localparam int S_IDLE = 0, S_SMIN = 1, S_SSEC = 2, S_RUN = 3, S_PAUSE = 4, S_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  int m_st, m_min, m_sec, m_pmin, m_psec, m_acnt;

  countdown_timer_ctrl_if bus ();

  countdown_timer_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Output vector: {MM:SS as BCD, set_field, running, alarm}.
  function automatic logic [19:0] dut_vec();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
            bus.set_field, bus.running, bus.alarm};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [1:0] sf;
    sf = (m_st == S_SMIN) ? 2'b01 : (m_st == S_SSEC) ? 2'b10 : 2'b00;
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
            sf, (m_st == S_RUN), (m_st == S_DONE)};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_min = 0; m_sec = 0; m_pmin = 0; m_psec = 0; m_acnt = 0;
  endtask

  // Time is handled as a total seconds count; digits are derived on demand.
  task automatic model_update(input logic sp, st, se, in, cl);
    int t;
    if (cl) begin
      model_reset();
    end else begin
      case (m_st)
        S_IDLE:  if (st && (m_min * 60 + m_sec) != 0) m_st = S_RUN;
                 else if (se) m_st = S_SMIN;
        S_SMIN:  if (se) m_st = S_SSEC;
                 else if (in) m_min = (m_min == MAX_MIN) ? 0 : m_min + 1;
        S_SSEC:  if (se) begin m_st = S_IDLE; m_pmin = m_min; m_psec = m_sec; end
                 else if (in) m_sec = (m_sec + 1) % 60;
        S_RUN: begin
          if (sp) begin
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60;
            m_sec = t % 60;
            if (t == 0) begin m_st = S_DONE; m_acnt = 0; end
            else if (st) m_st = S_PAUSE;
          end else if (st) m_st = S_PAUSE;
        end
        S_PAUSE: if (st) m_st = S_RUN;
        S_DONE:  if (sp) begin
                   m_acnt++;
                   if (m_acnt == ALARM_SECS) begin m_st = S_IDLE; m_min = m_pmin; m_sec = m_psec; end
                 end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic sp, st, se, in, cl);
    bus.sec_pulse = sp; bus.key_start = st; bus.key_set = se;
    bus.key_inc = in;   bus.key_clr = cl;
    @(posedge clk);
    model_update(sp, st, se, in, cl);
    #1;
    bus.sec_pulse = 1'b0; bus.key_start = 1'b0; bus.key_set = 1'b0;
    bus.key_inc = 1'b0;   bus.key_clr = 1'b0;
  endtask

  task automatic tick();     step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic k_start();  step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic k_set();    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic k_inc();    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic k_clr();    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic preset(input int mm, input int ss);
    k_clr(); k_set();
    for (int i = 0; i < mm; i++) k_inc();
    k_set();
    for (int i = 0; i < ss; i++) k_inc();
    k_set();
  endtask

  task automatic test_reset();
    bus.sec_pulse = 1'b0; bus.key_start = 1'b0; bus.key_set = 1'b0;
    bus.key_inc = 1'b0;   bus.key_clr = 1'b0;
    model_reset();
    #23;
    n_vec++;
    if (dut_vec() !== 20'h0) begin n_err++; $display("FAIL reset_hold: got %h want %h", dut_vec(), 20'h0); end
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_preset_run();
    preset(1, 5);
    n_vec++;
    if (dut_vec() !== {16'h0105, 4'b0000}) begin n_err++; $display("FAIL preset_0105: got %h want %h", dut_vec(), {16'h0105, 4'b0000}); end
    k_start(); idle(3); tick();
    n_vec++;
    if (dut_vec() !== {16'h0104, 4'b0010}) begin n_err++; $display("FAIL run_tick1: got %h want %h", dut_vec(), {16'h0104, 4'b0010}); end
    for (int i = 0; i < 4; i++) begin idle(2); tick(); end
    n_vec++;
    if (dut_vec() !== {16'h0100, 4'b0010}) begin n_err++; $display("FAIL run_tick5: got %h want %h", dut_vec(), {16'h0100, 4'b0010}); end
    tick();
    n_vec++;
    if (dut_vec() !== {16'h0059, 4'b0010}) begin n_err++; $display("FAIL run_tick6_borrow: got %h want %h", dut_vec(), {16'h0059, 4'b0010}); end
  endtask

  task automatic test_terminal();
    preset(0, 3); k_start();
    for (int i = 0; i < 3; i++) begin idle(1); tick(); end
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b0001}) begin n_err++; $display("FAIL terminal_alarm: got %h want %h", dut_vec(), {16'h0000, 4'b0001}); end
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b0001}) begin n_err++; $display("FAIL alarm_tick4_held: got %h want %h", dut_vec(), {16'h0000, 4'b0001}); end
    tick();
    n_vec++;
    if (dut_vec() !== {16'h0003, 4'b0000}) begin n_err++; $display("FAIL alarm_end_reload: got %h want %h", dut_vec(), {16'h0003, 4'b0000}); end
  endtask

  task automatic test_simultaneous();
    preset(0, 10); k_start();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec() !== {16'h0009, 4'b0000}) begin n_err++; $display("FAIL tick_and_pause: got %h want %h", dut_vec(), {16'h0009, 4'b0000}); end
    tick(); tick(); k_inc();
    n_vec++;
    if (dut_vec() !== {16'h0009, 4'b0000}) begin n_err++; $display("FAIL pause_holds: got %h want %h", dut_vec(), {16'h0009, 4'b0000}); end
    preset(0, 1); k_start();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b0001}) begin n_err++; $display("FAIL done_over_pause: got %h want %h", dut_vec(), {16'h0000, 4'b0001}); end
  endtask

  task automatic test_wrap();
    k_clr(); k_set();
    for (int i = 0; i < 59; i++) k_inc();
    n_vec++;
    if (dut_vec() !== {16'h5900, 4'b0100}) begin n_err++; $display("FAIL set_min_59: got %h want %h", dut_vec(), {16'h5900, 4'b0100}); end
    k_inc();
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b0100}) begin n_err++; $display("FAIL min_wrap: got %h want %h", dut_vec(), {16'h0000, 4'b0100}); end
    k_set();
    for (int i = 0; i < 59; i++) k_inc();
    n_vec++;
    if (dut_vec() !== {16'h0059, 4'b1000}) begin n_err++; $display("FAIL set_sec_59: got %h want %h", dut_vec(), {16'h0059, 4'b1000}); end
    k_inc();
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b1000}) begin n_err++; $display("FAIL sec_wrap: got %h want %h", dut_vec(), {16'h0000, 4'b1000}); end
    k_set(); k_start();
    n_vec++;
    if (dut_vec() !== 20'h0) begin n_err++; $display("FAIL start_at_zero: got %h want %h", dut_vec(), 20'h0); end
  endtask

  task automatic test_clear();
    preset(0, 2); k_start(); tick(); tick();
    n_vec++;
    if (dut_vec() !== {16'h0000, 4'b0001}) begin n_err++; $display("FAIL clr_pre_done: got %h want %h", dut_vec(), {16'h0000, 4'b0001}); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (dut_vec() !== 20'h0) begin n_err++; $display("FAIL clr_in_done: got %h want %h", dut_vec(), 20'h0); end
    k_start();
    n_vec++;
    if (dut_vec() !== 20'h0) begin n_err++; $display("FAIL clr_wiped_preset: got %h want %h", dut_vec(), 20'h0); end
  endtask

  task automatic test_async_reset();
    preset(0, 30); k_start(); tick();
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_vec++;
    if (dut_vec() !== 20'h0) begin n_err++; $display("FAIL async_reset: got %h want %h", dut_vec(), 20'h0); end
    model_reset();
    #12; @(negedge clk); rst_n = 1'b1;
    k_start();
    n_vec++;
    if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL after_async_reset: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    int r;
    logic sp, st, se, in, cl;
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      sp = ($urandom_range(0, 3) == 0);
      st = (r < 8);
      se = (r >= 8 && r < 18);
      in = (r >= 18 && r < 45);
      cl = (r == 99);
      step(sp, st, se, in, cl);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_preset_run();
    test_terminal();
    test_simultaneous();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Minutes/seconds countdown timer controller. It consumes the single-cycle 1 Hz tick (`sec_pulse`) and debounced single-cycle key strobes, and sequences a preset/run/pause/alarm state machine. It drives four BCD digits to the display driver and an alarm enable to the buzzer. It sits between the one-second pulse source and the 7-segment scan logic in the timer top level.

## Interface
- `MAX_MIN`, default 59: highest settable minute value; legal range 1..99.
- `ALARM_SECS`, default 5: number of `sec_pulse` ticks the alarm stays asserted; legal range 1..15.
- `clk` input 1: system clock (12 MHz).
- `rst_n` input 1: asynchronous active-low reset.
- `sec_pulse` input 1: 1 Hz tick, high for exactly one `clk` cycle.
- `key_start` input 1: start/pause strobe, one cycle.
- `key_set` input 1: enter set mode, or advance the set field; one cycle.
- `key_inc` input 1: increment the selected field; one cycle.
- `key_clr` input 1: clear everything; one cycle.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD digits of the current time.
- `set_field` output 2: 00 none, 01 minutes selected, 10 seconds selected.
- `running` output 1: high in RUN.
- `alarm` output 1: high in DONE.

## Operation
- States: IDLE, SET_MIN, SET_SEC, RUN, PAUSE, DONE. Reset enters IDLE.
- Registers:
  - current time `cur` (MM:SS, BCD).
  - preset `pre` (MM:SS, BCD).
  - alarm tick counter, 4 bits.
- IDLE:
  - `key_set` goes to SET_MIN.
  - `key_start` goes to RUN if `cur` is not 00:00; otherwise it is ignored.
- SET_MIN:
  - `key_inc` increments minutes, wrapping MAX_MIN to 00.
  - `key_set` goes to SET_SEC.
- SET_SEC:
  - `key_inc` increments seconds, wrapping 59 to 00.
  - `key_set` goes to IDLE and copies `cur` into `pre`.
- In both SET states, `key_start` is ignored and `sec_pulse` is ignored.
- RUN:
  - On `sec_pulse`, `cur` decrements. A seconds borrow from 00 gives 59 and decrements minutes.
  - When a decrement reaches 00:00, go to DONE and clear the alarm counter.
  - `key_start` goes to PAUSE.
- PAUSE:
  - `key_start` goes to RUN.
  - `sec_pulse` is ignored.
- DONE:
  - Each `sec_pulse` increments the alarm counter.
  - On the ALARM_SECS-th pulse, go to IDLE and reload `cur` from `pre`.
  - `key_start`, `key_set` and `key_inc` are ignored.
- `key_clr` in any state: go to IDLE, `cur` = 00:00, `pre` = 00:00, alarm counter = 0.
- Same-cycle priority: `key_clr` > `sec_pulse` decrement > `key_start` > `key_set` > `key_inc`.
  - In RUN, `sec_pulse` plus `key_start` together: the decrement is applied and the state goes to PAUSE.
  - In RUN, if that decrement reaches 00:00, DONE takes precedence over PAUSE.
- `key_inc` in IDLE, RUN, PAUSE or DONE: no effect.
- BCD digits never leave their legal range:
  - seconds tens 0..5, seconds ones 0..9.
  - minutes limited by MAX_MIN.

## Timing
- All outputs are registered. Every effect of an input sampled at edge N is visible after edge N (on the next cycle).
- Reset (asynchronous) values:
  - all digits 0.
  - `set_field` = 00.
  - `running` = 0.
  - `alarm` = 0.
  - state IDLE.
- Latency:
  - Key to state and output change: 1 cycle.
  - `sec_pulse` to digit change: 1 cycle.
  - The first decrement after entering RUN occurs on the next `sec_pulse`, which may come anywhere from 1 cycle to 1 s later. No tick re-phasing is performed.
- `alarm` rises in the same cycle the digits show 00:00.
  - It falls in the cycle after the ALARM_SECS-th tick.
  - In that same cycle the digits show `pre`.
- Reset or `key_clr` mid-RUN or mid-DONE takes effect in the next cycle, with no partial decrement.

## Structure
- Shared package `timer_pkg`:
  - state encoding constants.
  - `set_field` codes.
  - the BCD digit width constant (4).
- Sub-module `bcd_2digit_counter`, instantiated twice (minutes and seconds).
  - Parameter: LIMIT.
  - Inputs: `clk`, `rst_n`, `clr`, `load` (+ 8-bit BCD `load_val`), `inc`, `dec`.
  - Outputs: `tens`, `ones`, `is_zero`, `borrow` (combinational, high when `dec` is applied at 00).
  - `inc` wraps LIMIT to 00; `dec` wraps 00 to LIMIT.
- The top FSM drives the two counters:
  - seconds `dec` on a tick in RUN.
  - minutes `dec` from the seconds `borrow`.

## Test plan
- Preset and run: set 01:05 (`key_set`, `key_inc`×1, `key_set`, `key_inc`×5, `key_set`), then `key_start`. Required: 01:04 after tick 1, 01:00 after tick 5, 00:59 after tick 6.
- Terminal count: preset 00:03, start, 3 ticks. Required: 00:00 with `alarm`=1 and `running`=0; after 5 more ticks, `alarm`=0 and digits 00:03.
- Simultaneous events: in RUN at 00:10, `sec_pulse` and `key_start` in the same cycle. Required: 00:09 and PAUSE; further ticks leave 00:09.
- Wrap: in SET_SEC from 59, `key_inc` gives 00. In SET_MIN from 59, `key_inc` gives 00. `key_start` in IDLE at 00:00 leaves `running`=0.
- Clear/reset: `key_clr` mid-DONE gives `alarm`=0 and 00:00 next cycle. Asserting `rst_n` low mid-RUN gives all outputs 0 asynchronously.
